// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: op codes, FSM states and the memory-op decoder.
package mem_stage_pkg;

    localparam int         ALUOP_WIDTH = 8;
    localparam int         RAM_ADDR_W  = 17;
    localparam int         REG_W       = 32;
    localparam logic       RST_ENABLE  = 1'b1;

    localparam logic [7:0] EXE_NOP_OP  = 8'h00;
    localparam logic [7:0] EXE_OR_OP   = 8'h25;
    localparam logic [7:0] EXE_LB_OP   = 8'hE0;
    localparam logic [7:0] EXE_LH_OP   = 8'hE1;
    localparam logic [7:0] EXE_LW_OP   = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP  = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP  = 8'hE5;
    localparam logic [7:0] EXE_SB_OP   = 8'hE8;
    localparam logic [7:0] EXE_SH_OP   = 8'hE9;
    localparam logic [7:0] EXE_SW_OP   = 8'hEB;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_XFER,
        MEM_RDWAIT,
        MEM_DONE
    } mem_state_e;

    typedef struct packed {
        logic       isMem;
        logic       isStore;
        logic       isSigned;
        logic [2:0] size;
    } mem_op_t;

    // Classify an op code into access kind, byte count and extension mode.
    function automatic mem_op_t decodeOp(input logic [ALUOP_WIDTH-1:0] op);
        mem_op_t d;
        d = '0;
        case (op)
            EXE_LB_OP:  begin d.isMem = 1'b1; d.isSigned = 1'b1; d.size = 3'd1; end
            EXE_LH_OP:  begin d.isMem = 1'b1; d.isSigned = 1'b1; d.size = 3'd2; end
            EXE_LW_OP:  begin d.isMem = 1'b1; d.isSigned = 1'b1; d.size = 3'd4; end
            EXE_LBU_OP: begin d.isMem = 1'b1; d.size = 3'd1; end
            EXE_LHU_OP: begin d.isMem = 1'b1; d.size = 3'd2; end
            EXE_SB_OP:  begin d.isMem = 1'b1; d.isStore = 1'b1; d.size = 3'd1; end
            EXE_SH_OP:  begin d.isMem = 1'b1; d.isStore = 1'b1; d.size = 3'd2; end
            EXE_SW_OP:  begin d.isMem = 1'b1; d.isStore = 1'b1; d.size = 3'd4; end
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide synchronous RAM port between the MEM stage (master) and the data RAM (slave).
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int AW = RAM_ADDR_W
) ();

    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    modport master (output ram_addr, output ram_wr, output ram_dout, input  ram_din);
    modport slave  (input  ram_addr, input  ram_wr, input  ram_dout, output ram_din);

endinterface

// File: rtl/mem_stage_ld_ext.sv
// Load result extension: widens the assembled load bytes to 32 bits, sign or zero filled.
module mem_ld_ext
    import mem_stage_pkg::*;
(
    input  logic [REG_W-1:0] buf_i,
    input  logic [2:0]       size_i,
    input  logic             signed_i,
    output logic [REG_W-1:0] data_o
);

    // Pick the fill bit from the top of the loaded field and replicate it upward.
    always_comb begin
        data_o = buf_i;
        case (size_i)
            3'd1:    data_o = {{24{signed_i & buf_i[7]}}, buf_i[7:0]};
            3'd2:    data_o = {{16{signed_i & buf_i[15]}}, buf_i[15:0]};
            default: data_o = buf_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: sequences loads/stores one byte per cycle over the RAM port and stalls the pipeline.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ALUOP_W = ALUOP_WIDTH,
    parameter int RAM_AW  = RAM_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         wd_i,
    input  logic               wreg_i,
    input  logic [REG_W-1:0]   wdata_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [RAM_AW-1:0]  mem_addr_i,
    input  logic [REG_W-1:0]   mem_wdata_i,
    output logic [4:0]         wd_o,
    output logic               wreg_o,
    output logic [REG_W-1:0]   wdata_o,
    output logic               stall_req_o,
    mem_stage_if.master        ram
);

    mem_op_t           dec;
    mem_state_e        state_q;
    logic [1:0]        idx_q;
    logic [1:0]        lastIdx;
    logic [2:0]        size_q;
    logic              isStore_q;
    logic              isSigned_q;
    logic [REG_W-1:0]  storeData_q;
    logic [REG_W-1:0]  loadBuf_q;
    logic [REG_W-1:0]  loadExt;
    logic [RAM_AW-1:0] ramAddr_q;
    logic              ramWr_q;
    logic [7:0]        ramDout_q;

    assign dec     = decodeOp(aluop_i);
    assign lastIdx = 2'(size_q - 3'd1);

    mem_ld_ext u_ld_ext (
        .buf_i    (loadBuf_q),
        .size_i   (size_q),
        .signed_i (isSigned_q),
        .data_o   (loadExt)
    );

    // Access FSM: latches the request in IDLE, walks the bytes, and drives the RAM port from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MEM_IDLE;
            idx_q       <= '0;
            size_q      <= '0;
            isStore_q   <= 1'b0;
            isSigned_q  <= 1'b0;
            storeData_q <= '0;
            loadBuf_q   <= '0;
            ramAddr_q   <= '0;
            ramWr_q     <= 1'b0;
            ramDout_q   <= '0;
        end else begin
            unique case (state_q)
                MEM_IDLE: begin
                    if (dec.isMem) begin
                        state_q     <= MEM_XFER;
                        idx_q       <= '0;
                        size_q      <= dec.size;
                        isStore_q   <= dec.isStore;
                        isSigned_q  <= dec.isSigned;
                        storeData_q <= mem_wdata_i;
                        loadBuf_q   <= '0;
                        ramAddr_q   <= mem_addr_i;
                        ramWr_q     <= dec.isStore;
                        ramDout_q   <= dec.isStore ? mem_wdata_i[7:0] : 8'h00;
                    end
                end
                MEM_XFER: begin
                    if (!isStore_q && idx_q != 2'd0) begin
                        loadBuf_q[{idx_q - 2'd1, 3'b000} +: 8] <= ram.ram_din;
                    end
                    if (idx_q == lastIdx) begin
                        state_q   <= isStore_q ? MEM_DONE : MEM_RDWAIT;
                        ramAddr_q <= '0;
                        ramWr_q   <= 1'b0;
                        ramDout_q <= '0;
                    end else begin
                        idx_q     <= idx_q + 2'd1;
                        ramAddr_q <= ramAddr_q + RAM_AW'(1);
                        if (isStore_q) begin
                            ramDout_q <= storeData_q[{idx_q + 2'd1, 3'b000} +: 8];
                        end
                    end
                end
                MEM_RDWAIT: begin
                    loadBuf_q[{lastIdx, 3'b000} +: 8] <= ram.ram_din;
                    state_q <= MEM_DONE;
                end
                MEM_DONE: begin
                    state_q <= MEM_IDLE;
                    idx_q   <= '0;
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    // Writeback and stall outputs: pass-through when idle, bubble while busy, result on DONE.
    always_comb begin
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stall_req_o = 1'b0;
        if (rst != RST_ENABLE) begin
            unique case (state_q)
                MEM_IDLE: begin
                    if (dec.isMem) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                MEM_XFER, MEM_RDWAIT: stall_req_o = 1'b1;
                MEM_DONE: begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = isStore_q ? '0 : loadExt;
                end
                default: stall_req_o = 1'b0;
            endcase
        end
    end

    assign ram.ram_addr = ramAddr_q;
    assign ram.ram_wr   = ramWr_q;
    assign ram.ram_dout = ramDout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed and random loads/stores against a byte-array memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int AW       = RAM_ADDR_W;
    localparam int MEM_SIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    wd_i;
    logic          wreg_i;
    logic [31:0]   wdata_i;
    logic [7:0]    aluop_i;
    logic [AW-1:0] mem_addr_i;
    logic [31:0]   mem_wdata_i;
    logic [4:0]    wd_o;
    logic          wreg_o;
    logic [31:0]   wdata_o;
    logic          stall_req_o;

    logic          pokeEn;
    logic [AW-1:0] pokeAddr;
    logic [7:0]    pokeData;

    bit [7:0] ram    [MEM_SIZE];
    bit [7:0] shadow [MEM_SIZE];

    int testsRun    = 0;
    int testsFailed = 0;

    mem_stage_if #(.AW(AW)) ramIf ();

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .aluop_i     (aluop_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o),
        .ram         (ramIf)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Synchronous byte RAM: write on the edge, read data valid the cycle after the address.
    always @(posedge clk) begin
        if (ramIf.ram_wr) ram[ramIf.ram_addr] <= ramIf.ram_dout;
        else if (pokeEn) ram[pokeAddr] <= pokeData;
        ramIf.ram_din <= ram[ramIf.ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [AW-1:0] addr, input logic [31:0] sdata,
                                 input logic [4:0] wd, input logic wreg, input logic [31:0] alu);
        @(posedge clk);
        #1;
        aluop_i     = op;
        mem_addr_i  = addr;
        mem_wdata_i = sdata;
        wd_i        = wd;
        wreg_i      = wreg;
        wdata_i     = alu;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        pokeAddr  = a;
        pokeData  = d;
        pokeEn    = 1'b1;
        shadow[a] = d;
        @(posedge clk);
        #1;
        pokeEn = 1'b0;
    endtask

    task automatic opInfo(input logic [7:0] op, output int n, output bit ld, output bit st, output bit sgn);
        n = 0; ld = 0; st = 0; sgn = 0;
        case (op)
            EXE_LB_OP:  begin n = 1; ld = 1; sgn = 1; end
            EXE_LH_OP:  begin n = 2; ld = 1; sgn = 1; end
            EXE_LW_OP:  begin n = 4; ld = 1; sgn = 1; end
            EXE_LBU_OP: begin n = 1; ld = 1; end
            EXE_LHU_OP: begin n = 2; ld = 1; end
            EXE_SB_OP:  begin n = 1; st = 1; end
            EXE_SH_OP:  begin n = 2; st = 1; end
            EXE_SW_OP:  begin n = 4; st = 1; end
            default:    n = 0;
        endcase
    endtask

    function automatic logic [31:0] refLoad(input int n, input bit sgn, input logic [AW-1:0] a);
        logic [63:0]   v;
        logic [AW-1:0] p;
        v = '0;
        for (int i = 0; i < n; i++) begin
            p = a + AW'(i);
            v = v | (64'(shadow[p]) << (8 * i));
        end
        if (sgn && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v[31:0];
    endfunction

    task automatic executeOp(input string tag, input logic [7:0] op, input logic [AW-1:0] addr,
                             input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                             input logic [31:0] alu);
        int            n;
        bit            ld, st, sgn, done;
        int            stalls, expStalls;
        logic [31:0]   expData;
        logic [AW-1:0] p;
        int            wrAddr[$];
        int            wrByte[$];
        opInfo(op, n, ld, st, sgn);
        if (ld) begin
            expData = refLoad(n, sgn, addr); expStalls = n + 2;
        end else if (st) begin
            expData = 32'h0; expStalls = n + 1;
        end else begin
            expData = alu; expStalls = 0;
        end
        stalls = 0;
        done   = 0;
        applyStimulus(op, addr, sdata, wd, wreg, alu);
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (stall_req_o) begin
                stalls++;
                if (ramIf.ram_wr) begin
                    wrAddr.push_back(int'(ramIf.ram_addr));
                    wrByte.push_back(int'(ramIf.ram_dout));
                end
            end else begin
                done = 1;
            end
        end
        checkOutput({tag, "/completed"}, 32'(done), 32'd1);
        checkOutput({tag, "/stalls"}, 32'(stalls), 32'(expStalls));
        checkOutput({tag, "/wd_o"}, 32'(wd_o), 32'(wd));
        checkOutput({tag, "/wreg_o"}, 32'(wreg_o), 32'(wreg));
        checkOutput({tag, "/wdata_o"}, wdata_o, expData);
        checkOutput({tag, "/ram_wr_o"}, 32'(ramIf.ram_wr), 32'd0);
        checkOutput({tag, "/ram_addr_o"}, 32'(ramIf.ram_addr), 32'd0);
        checkOutput({tag, "/writes"}, 32'(wrAddr.size()), st ? 32'(n) : 32'd0);
        if (st) begin
            for (int i = 0; i < n; i++) begin
                p = addr + AW'(i);
                shadow[p] = sdata[8*i +: 8];
                if (i < wrAddr.size()) begin
                    checkOutput({tag, "/wr_addr"}, 32'(wrAddr[i]), 32'(p));
                    checkOutput({tag, "/wr_byte"}, 32'(wrByte[i]), 32'(sdata[8*i +: 8]));
                end
                checkOutput({tag, "/ram_content"}, 32'(ram[p]), 32'(shadow[p]));
            end
        end
    endtask

    logic [7:0] opList [9] = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
                               EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_OR_OP};

    // Directed scenarios first, then a random mix, then reset in the middle of a store.
    initial begin
        logic [7:0]    op;
        logic [AW-1:0] a;
        rst         = 1'b1;
        pokeEn      = 1'b0;
        pokeAddr    = '0;
        pokeData    = '0;
        aluop_i     = EXE_SW_OP;
        mem_addr_i  = 17'h00123;
        mem_wdata_i = 32'hCAFEF00D;
        wd_i        = 5'd7;
        wreg_i      = 1'b1;
        wdata_i     = 32'h55AA55AA;

        repeat (2) @(negedge clk);
        checkOutput("reset/stall_req_o", 32'(stall_req_o), 32'd0);
        checkOutput("reset/ram_wr_o", 32'(ramIf.ram_wr), 32'd0);
        checkOutput("reset/ram_addr_o", 32'(ramIf.ram_addr), 32'd0);
        checkOutput("reset/wd_o", 32'(wd_o), 32'd0);
        checkOutput("reset/wreg_o", 32'(wreg_o), 32'd0);
        checkOutput("reset/wdata_o", wdata_o, 32'd0);
        #1;
        aluop_i = EXE_NOP_OP;
        rst     = 1'b0;

        poke(17'h00200, 8'h80);
        poke(17'h1FFFF, 8'h34);
        poke(17'h00000, 8'h92);
        poke(17'h00300, 8'h78);
        poke(17'h00301, 8'hA6);
        poke(17'h00302, 8'h34);
        poke(17'h00303, 8'hF2);
        for (int i = 0; i < 16; i++) poke(17'h00400 + AW'(i), 8'($urandom));

        executeOp("alu_or", EXE_OR_OP, '0, 32'h0, 5'd5, 1'b1, 32'h12345678);
        executeOp("sw", EXE_SW_OP, 17'h00100, 32'hDEADBEEF, 5'd0, 1'b0, 32'h100);
        executeOp("lb", EXE_LB_OP, 17'h00200, 32'h0, 5'd3, 1'b1, 32'h200);
        executeOp("lbu", EXE_LBU_OP, 17'h00200, 32'h0, 5'd4, 1'b1, 32'h200);
        executeOp("lh_wrap", EXE_LH_OP, 17'h1FFFF, 32'h0, 5'd6, 1'b1, 32'h1FFFF);
        executeOp("lw", EXE_LW_OP, 17'h00300, 32'h0, 5'd8, 1'b1, 32'h300);
        executeOp("sb", EXE_SB_OP, 17'h00304, 32'h000000AA, 5'd0, 1'b0, 32'h304);
        checkOutput("sb/byte_0x304", 32'(ram[17'h00304]), 32'h000000AA);

        for (int i = 0; i < 24; i++) begin
            op = opList[$urandom_range(0, 8)];
            if ($urandom_range(0, 3) == 0) a = 17'h1FFFD + AW'($urandom_range(0, 5));
            else a = 17'h00400 + AW'($urandom_range(0, 15));
            executeOp($sformatf("rand%0d", i), op, a, $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), $urandom);
        end

        applyStimulus(EXE_SW_OP, 17'h00500, 32'h11223344, 5'd0, 1'b0, 32'h500);
        repeat (3) @(negedge clk);
        checkOutput("rst_mid/ram_wr_before", 32'(ramIf.ram_wr), 32'd1);
        checkOutput("rst_mid/ram_addr_before", 32'(ramIf.ram_addr), 32'h501);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid/ram_wr_o", 32'(ramIf.ram_wr), 32'd0);
        checkOutput("rst_mid/stall_req_o", 32'(stall_req_o), 32'd0);
        checkOutput("rst_mid/ram_addr_o", 32'(ramIf.ram_addr), 32'd0);
        shadow[17'h00500] = 8'h44;
        @(posedge clk);
        #1;
        aluop_i = EXE_OR_OP;
        wd_i    = 5'd9;
        wreg_i  = 1'b1;
        wdata_i = 32'hA5A5A5A5;
        @(negedge clk);
        checkOutput("rst_hold/wd_o", 32'(wd_o), 32'd0);
        checkOutput("rst_hold/wdata_o", wdata_o, 32'd0);
        #1;
        rst = 1'b0;
        executeOp("post_rst_or", EXE_OR_OP, '0, 32'h0, 5'd9, 1'b1, 32'h0BADCAFE);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rst_mid/partial_store", 32'(ram[17'h00500 + AW'(i)]), 32'(shadow[17'h00500 + AW'(i)]));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
